det_ser: RTL and testbench
==========================

DET_SER -- requirements
Module: det_ser

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  one-cycle pulse; a result frame is present on in_data.
REQ-005 in_mode  input  2  frame format, sampled with in_valid: 00=2x2, 01=3x3, 10=4x4, 11=treated as 4x4.
REQ-006 in_data  input  207  packed determinant result from the determinant calculator.
REQ-007 in_ready  output  1  block can accept a frame this cycle; combinational.
REQ-008 out_valid  output  1  out_data holds a valid word; registered.
REQ-009 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-010 out_data  output  52  signed result word; registered.
REQ-011 out_idx  output  4  index of the current word within its frame; registered.
REQ-012 out_last  output  1  current word is the final word of its frame; registered.
REQ-013 err  output  1  sticky overflow flag; registered.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 in_ready SHALL be 1 in IDLE, and 1 in SEND only when out_valid & out_ready & out_last; otherwise 0.
REQ-016 When in_valid & in_ready, the block SHALL capture in_data and in_mode into a 207-bit frame buffer and a mode register, and enter or stay in SEND.
REQ-017 Accept at edge k SHALL present word 0 on the outputs from edge k+1 (latency 1), with out_valid=1 and out_idx=0.
REQ-018 2x2 frames SHALL produce 9 words: word i = in_data[206-23i -: 23], sign-extended to 52 bits (word0 = bits 206:184, word8 = bits 22:0).
REQ-019 3x3 frames SHALL produce 4 words: word i = in_data[203-51i -: 51], sign-extended to 52 bits (word0 = bits 203:153); bits 206:204 are ignored.
REQ-020 4x4 frames SHALL produce 4 words, least significant first: word0=[51:0], word1=[103:52], word2=[155:104], word3 = [206:156] sign-extended by bit 206.
REQ-021 out_last SHALL be 1 exactly on word 8 (2x2) or word 3 (3x3/4x4).
REQ-022 While out_valid & ~out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-023 On out_valid & out_ready & ~out_last, the next word SHALL appear at the next edge.
REQ-024 On the final handshake without a new accept, the FSM SHALL return to IDLE, and out_valid and out_data SHALL be 0 at the next edge.
REQ-025 On the final handshake with a simultaneous accept, word 0 of the new frame SHALL appear at the next edge with no bubble.
REQ-026 in_valid while in_ready=0 SHALL drop that frame, leave the frame in progress undisturbed, and set err=1 at the next edge.
REQ-027 err SHALL stay 1 until reset.
REQ-028 In IDLE, out_idx and out_last SHALL be 0.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately clear out_valid, out_data, out_idx, out_last and err to 0, and force IDLE.
REQ-030 Reset mid-frame SHALL discard the frame; after release, in_ready=1 and no stale word is emitted.
REQ-031 The frame buffer and mode register need no reset.

Verification
REQ-032 2x2: accept in_mode=00 with the top 23 bits=23'h7FFFFF and the low 23 bits=23'h000005, out_ready=1 -> 9 consecutive words; word0=-1 (52'hF..F), word8=5, out_last on idx 8 only.
REQ-033 3x3: accept in_mode=01 with [203:153]=51'h4000000000000 -> word0=52'hC000000000000 (sign-extended); 4 words; bits 206:204=3'b111 do not affect any output.
REQ-034 4x4 with backpressure: accept in_mode=10 with in_data=-2 (all ones except bit 0), out_ready toggling 1,0,0,1 -> words FFFFFFFFFFFFE, then F..F x3; each word holds while out_ready=0.
REQ-035 Back-to-back: a second in_valid coincident with the last-word handshake -> new word0 at the next edge; err stays 0.
REQ-036 Overflow: in_valid during word 2 of a 2x2 frame -> frame dropped, the current frame completes intact, err=1 until rst_n.
REQ-037 Reset mid-frame: rst_n low during word 1 -> outputs 0 asynchronously; after release, the next accepted frame starts at out_idx=0.

Source files
------------

// File: rtl/det_ser.sv
// Serialises one packed determinant result frame into a stream of 52-bit signed
// words, one word per downstream handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no frame held; outputs parked at zero, ready for a frame
// SEND  | streaming words of the buffered frame to the downstream side
module det_ser (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [1:0]   in_mode,
    input  logic [206:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [51:0]  out_data,
    output logic [3:0]   out_idx,
    output logic         out_last,
    output logic         err
);

    localparam logic IDLE = 1'b0;
    localparam logic SEND = 1'b1;

    localparam logic [1:0] MODE_2X2 = 2'b00;
    localparam logic [1:0] MODE_3X3 = 2'b01;

    logic         state;
    logic [206:0] frame_buf;
    logic [1:0]   mode_reg;
    logic         accept;
    logic         fire;
    logic [3:0]   next_idx;

    // Word extraction; mode 11 falls through to the 4x4 layout.
    function automatic logic [51:0] pick_word(input logic [206:0] frame,
                                              input logic [1:0]   mode,
                                              input logic [3:0]   idx);
        logic [7:0]  amt;
        logic [22:0] w23;
        logic [50:0] w51;
        logic [51:0] w52;
        logic [51:0] word;
        amt  = 8'd0;
        word = '0;
        case (mode)
            MODE_2X2: begin
                amt  = 8'd23 * (8'd8 - {4'd0, idx});
                w23  = 23'(frame >> amt);
                word = {{29{w23[22]}}, w23};
            end
            MODE_3X3: begin
                amt  = 8'd51 * (8'd3 - {4'd0, idx});
                w51  = 51'(frame >> amt);
                word = {w51[50], w51};
            end
            default: begin
                amt  = 8'd52 * {4'd0, idx};
                w52  = 52'(frame >> amt);
                word = (idx == 4'd3) ? {w52[50], w52[50:0]} : w52;
            end
        endcase
        return word;
    endfunction

    function automatic logic [3:0] last_idx(input logic [1:0] mode);
        return (mode == MODE_2X2) ? 4'd8 : 4'd3;
    endfunction

    assign fire     = out_valid && out_ready;
    assign in_ready = (state == IDLE) || (fire && out_last);
    assign accept   = in_valid && in_ready;
    assign next_idx = out_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (accept) begin
            frame_buf <= in_data;
            mode_reg  <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_data  <= pick_word(in_data, in_mode, 4'd0);
            out_idx   <= 4'd0;
            out_last  <= 1'b0;
        end else if (fire) begin
            if (out_last) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_idx   <= '0;
                out_last  <= 1'b0;
            end else begin
                out_data  <= pick_word(frame_buf, mode_reg, next_idx);
                out_idx   <= next_idx;
                out_last  <= (next_idx == last_idx(mode_reg));
            end
        end
    end

    // A frame offered while busy is lost; flag it until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_det_ser.sv
// Directed bench for det_ser: hand-computed word values for every frame format,
// backpressure, back-to-back frames, overflow and mid-frame reset.
module tb_det_ser;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   in_mode;
    logic [206:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [51:0]  out_data;
    logic [3:0]   out_idx;
    logic         out_last;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [51:0]  exp_w [0:8];
    logic [206:0] frame_2x2;

    det_ser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input int i, input int n);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_idx"},   64'(out_idx),   64'(i));
        check({tag, "_last"},  64'(out_last),  64'(i == n - 1));
        check({tag, "_data"},  64'(out_data),  64'(exp_w[i]));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_data"},  64'(out_data),  64'd0);
        check({tag, "_idle_idx"},   64'(out_idx),   64'd0);
        check({tag, "_idle_last"},  64'(out_last),  64'd0);
        check({tag, "_idle_rdy"},   64'(in_ready),  64'd1);
    endtask

    task automatic send(input logic [1:0] mode, input logic [206:0] data);
        in_valid = 1'b1;
        in_mode  = mode;
        in_data  = data;
        step();
        in_valid = 1'b0;
    endtask

    task automatic load_2x2();
        frame_2x2 = {23'h7FFFFF, 23'h000001, 23'h123456, 23'h3FFFFF, 23'h400000,
                     23'h000010, 23'h2AAAAA, 23'h555555, 23'h000005};
        exp_w[0] = 52'hFFFFFFFFFFFFF;
        exp_w[1] = 52'h0000000000001;
        exp_w[2] = 52'h0000000123456;
        exp_w[3] = 52'h00000003FFFFF;
        exp_w[4] = 52'hFFFFFFFC00000;
        exp_w[5] = 52'h0000000000010;
        exp_w[6] = 52'h00000002AAAAA;
        exp_w[7] = 52'hFFFFFFFD55555;
        exp_w[8] = 52'h0000000000005;
    endtask

    task automatic load_3x3();
        exp_w[0] = 52'hC000000000000;
        exp_w[1] = 52'h0000000000001;
        exp_w[2] = 52'hFFFFFFFFFFFFF;
        exp_w[3] = 52'h000000000002A;
    endtask

    task automatic load_4x4_seq();
        exp_w[0] = 52'h0000000000001;
        exp_w[1] = 52'h0000000000002;
        exp_w[2] = 52'h0000000000003;
        exp_w[3] = 52'hC000000000000;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_err",   64'(err),       64'd0);
        check("rst_rdy",   64'(in_ready),  64'd1);
        #10 rst_n = 1'b1;
        step();

        // 2x2 frame streamed with out_ready held high
        load_2x2();
        out_ready = 1'b1;
        send(2'b00, frame_2x2);
        for (int i = 0; i < 9; i++) begin
            check_word("f2x2", i, 9);
            step();
        end
        check_idle("f2x2");

        // 3x3 frame; the three unused top bits are ones
        load_3x3();
        send(2'b01, {3'b111, 51'h4000000000000, 51'h1, 51'h7FFFFFFFFFFFF, 51'h2A});
        for (int i = 0; i < 4; i++) begin
            check_word("f3x3", i, 4);
            step();
        end
        check_idle("f3x3");

        // 4x4 frame of -2 with two stall cycles on every word
        exp_w[0] = 52'hFFFFFFFFFFFFE;
        exp_w[1] = 52'hFFFFFFFFFFFFF;
        exp_w[2] = 52'hFFFFFFFFFFFFF;
        exp_w[3] = 52'hFFFFFFFFFFFFF;
        out_ready = 1'b0;
        send(2'b10, ~207'd1);
        for (int i = 0; i < 4; i++) begin
            check_word("bp_pre", i, 4);
            step();
            check_word("bp_hold1", i, 4);
            step();
            check_word("bp_hold2", i, 4);
            check("bp_rdy_stall", 64'(in_ready), 64'd0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check_idle("bp");

        // mode 11 as 4x4, distinct words, then back-to-back into a 3x3 frame
        load_4x4_seq();
        out_ready = 1'b1;
        send(2'b11, {51'h4000000000000, 52'h3, 52'h2, 52'h1});
        for (int i = 0; i < 3; i++) begin
            check_word("f4x4", i, 4);
            step();
        end
        check_word("f4x4", 3, 4);
        in_valid = 1'b1;
        in_mode  = 2'b01;
        in_data  = {3'b000, 51'h4000000000000, 51'h1, 51'h7FFFFFFFFFFFF, 51'h2A};
        check("b2b_rdy", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        load_3x3();
        for (int i = 0; i < 4; i++) begin
            check_word("b2b", i, 4);
            check("b2b_err", 64'(err), 64'd0);
            step();
        end
        check_idle("b2b");

        // overflow: a frame offered during word 2 is dropped
        load_2x2();
        send(2'b00, frame_2x2);
        for (int i = 0; i < 9; i++) begin
            check_word("ovf", i, 9);
            if (i == 2) begin
                in_valid = 1'b1;
                in_mode  = 2'b10;
                in_data  = '0;
                check("ovf_rdy", 64'(in_ready), 64'd0);
            end
            step();
            in_valid = 1'b0;
            if (i >= 2) check("ovf_err", 64'(err), 64'd1);
        end
        check_idle("ovf");
        step();
        check("ovf_err_sticky", 64'(err), 64'd1);

        // reset during word 1 clears outputs without a clock edge
        send(2'b00, frame_2x2);
        step();
        check_word("mid", 1, 9);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_data",  64'(out_data),  64'd0);
        check("async_idx",   64'(out_idx),   64'd0);
        check("async_err",   64'(err),       64'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        check_idle("post_rst");
        load_4x4_seq();
        send(2'b10, {51'h4000000000000, 52'h3, 52'h2, 52'h1});
        for (int i = 0; i < 4; i++) begin
            check_word("post_rst", i, 4);
            step();
        end
        check_idle("post_rst_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
